// File: rtl/ula_arbiter.sv
// ula_arbiter
//
// Shares one combinational 32-bit ULA between two requesters:
// the instruction datapath (port 0) and an auxiliary unit such as
// address or branch calculation (port 1).
//
// Requesters are arbitrated round-robin. The winner's opcode and operands
// are latched into registers that drive the ULA. The ULA result and zero
// flag are then registered and returned to the winner with a one-cycle
// ack pulse. Each operation takes IDLE -> EXEC -> RESP, so at most one
// operation completes every three cycles.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   req0/op0/a0/b0   request, opcode and operands from requester 0
//   ack0             one-cycle pulse; res/zero valid for requester 0
//   req1/op1/a1/b1   request, opcode and operands from requester 1
//   ack1             one-cycle pulse; res/zero valid for requester 1
//   ula_a/ula_b      registered operands driving the ULA
//   ula_op           registered opcode driving the ULA
//   ula_s/ula_z      ULA result and zero flag
//   res/zero         captured result and zero flag
//   busy             high whenever the arbiter is not idle
//   grant            index of the most recently granted requester
module ula_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic [OPW-1:0]   op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [OPW-1:0]   op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic [WIDTH-1:0] ula_a,
   output logic [WIDTH-1:0] ula_b,
   output logic [OPW-1:0]   ula_op,
   input  logic [WIDTH-1:0] ula_s,
   input  logic             ula_z,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             busy,
   output logic             grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   sel;   // requester chosen in IDLE
   logic   load;  // latch the chosen request on this edge

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and arbitration decision
   always_comb begin
      state_next = state;
      load       = 1'b0;
      sel        = grant;
      case (state)
         IDLE: begin
            // On a tie, the requester that was not served last wins.
            if (req0 && req1) begin
               sel = ~grant;
            end else if (req1) begin
               sel = 1'b1;
            end else begin
               sel = 1'b0;
            end
            if (req0 || req1) begin
               load       = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, result capture and ack generation
   always_ff @(posedge clock) begin
      if (reset) begin
         ula_a  <= '0;
         ula_b  <= '0;
         ula_op <= '0;
         res    <= '0;
         zero   <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         grant  <= 1'b1;  // lets requester 0 win the first tie
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         if (load) begin
            ula_a  <= sel ? a1  : a0;
            ula_b  <= sel ? b1  : b0;
            ula_op <= sel ? op1 : op0;
            grant  <= sel;
         end
         // Capturing in EXEC makes the ack land in RESP, alongside valid res/zero.
         if (state == EXEC) begin
            res  <= ula_s;
            zero <= ula_z;
            ack0 <= ~grant;
            ack1 <= grant;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
module tb_ula_arbiter;

   logic        clock;
   logic        reset;
   logic        req0, req1;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic        ack0, ack1;
   logic [31:0] ula_a, ula_b;
   logic [3:0]  ula_op;
   logic [31:0] ula_s;
   logic        ula_z;
   logic [31:0] res;
   logic        zero;
   logic        busy;
   logic        grant;

   ula_arbiter #(.WIDTH(32), .OPW(4)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
      .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
      .ula_s(ula_s), .ula_z(ula_z),
      .res(res), .zero(zero), .busy(busy), .grant(grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Combinational ULA driven by the arbiter's registered ports
   always_comb begin
      ula_s = 32'd0;
      case (ula_op)
         4'b0000: ula_s = ula_a & ula_b;
         4'b0001: ula_s = ula_a | ula_b;
         4'b0010: ula_s = ula_a + ula_b;
         4'b0110: ula_s = ula_a - ula_b;
         4'b0011: ula_s = ula_a << ula_b[4:0];
         4'b0100: ula_s = ula_a >> ula_b[4:0];
         4'b0111: ula_s = {31'd0, ($signed(ula_a) < $signed(ula_b))};
         4'b1100: ula_s = ~(ula_a | ula_b);
         default: ula_s = 32'd0;
      endcase
      ula_z = (ula_s == 32'd0);
   end

   typedef struct {
      logic        port;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   ack_cyc[$];
   logic ack_port[$];
   int   cyc;
   int   checks;
   int   errors;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic p, input logic [31:0] r, input logic z);
      exp_t e;
      e.port = p;
      e.res  = r;
      e.zero = z;
      sb.push_back(e);
   endtask

   // Monitor: pops the scoreboard whenever an ack is presented
   always @(negedge clock) begin
      if (ack0 || ack1) begin
         exp_t e;
         check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
         check("ack_while_busy", {31'd0, busy}, 32'd1);
         ack_cyc.push_back(cyc);
         ack_port.push_back(ack1);
         if (sb.size() == 0) begin
            check("unexpected_ack", {31'd0, ack1}, 32'hFFFFFFFF);
         end else begin
            e = sb.pop_front();
            check("sb_port", {31'd0, ack1}, {31'd0, e.port});
            check("sb_res", res, e.res);
            check("sb_zero", {31'd0, zero}, {31'd0, e.zero});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_one(input logic p, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      if (p) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      reset  = 1'b1;
      req0 = 1'b0; op0 = 4'd0; a0 = 32'd0; b0 = 32'd0;
      req1 = 1'b0; op1 = 4'd0; a1 = 32'd0; b1 = 32'd0;
      tick();
      tick();

      // Reset state
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      check("rst_ack1", {31'd0, ack1}, 32'd0);
      check("rst_res", res, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      check("rst_ula_a", ula_a, 32'd0);
      check("rst_ula_b", ula_b, 32'd0);
      check("rst_ula_op", {28'd0, ula_op}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_grant", {31'd0, grant}, 32'd1);
      reset = 1'b0;

      // Single ADD 5+7 from requester 0, latency check
      push_exp(1'b0, 32'd12, 1'b0);
      req0 = 1'b1; op0 = 4'b0010; a0 = 32'd5; b0 = 32'd7;
      tick();
      check("t1_ula_a", ula_a, 32'd5);
      check("t1_ula_b", ula_b, 32'd7);
      check("t1_ula_op", {28'd0, ula_op}, 32'd2);
      check("t1_busy_exec", {31'd0, busy}, 32'd1);
      req0 = 1'b0;
      tick();
      check("t1_ack0", {31'd0, ack0}, 32'd1);
      check("t1_res", res, 32'd12);
      tick();
      check("t1_busy_idle", {31'd0, busy}, 32'd0);
      check("t1_ack0_clear", {31'd0, ack0}, 32'd0);
      check("t1_res_hold", res, 32'd12);

      // Simultaneous requests after reset: requester 0 wins first
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push_exp(1'b0, 32'd0, 1'b1);
      push_exp(1'b1, 32'd2, 1'b0);
      req0 = 1'b1; op0 = 4'b0110; a0 = 32'd3; b0 = 32'd3;
      req1 = 1'b1; op1 = 4'b0010; a1 = 32'd1; b1 = 32'd1;
      tick();
      check("t2_grant0", {31'd0, grant}, 32'd0);
      check("t2_ula_op", {28'd0, ula_op}, 32'd6);
      req0 = 1'b0;
      tick();
      check("t2_ack0", {31'd0, ack0}, 32'd1);
      check("t2_zero", {31'd0, zero}, 32'd1);
      tick();
      tick();
      req1 = 1'b0;
      tick();
      check("t2_ack1", {31'd0, ack1}, 32'd1);
      check("t2_res1", res, 32'd2);
      tick();
      check("t2_grant1", {31'd0, grant}, 32'd1);

      // Both held for four operations: 0,1,0,1, three cycles apart
      ack_cyc.delete();
      ack_port.delete();
      push_exp(1'b0, 32'd30, 1'b0);
      push_exp(1'b1, 32'd42, 1'b0);
      push_exp(1'b0, 32'd30, 1'b0);
      push_exp(1'b1, 32'd42, 1'b0);
      req0 = 1'b1; op0 = 4'b0010; a0 = 32'd10; b0 = 32'd20;
      req1 = 1'b1; op1 = 4'b0110; a1 = 32'd50; b1 = 32'd8;
      for (int i = 0; i < 10; i++) tick();
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("t3_ack_count", ack_cyc.size(), 32'd4);
      if (ack_cyc.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("t3_order", {31'd0, ack_port[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
         end
         for (int i = 1; i < 4; i++) begin
            check("t3_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd3);
         end
      end

      // Signed SLT from requester 1
      push_exp(1'b1, 32'd1, 1'b0);
      run_one(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1);
      check("t4_slt_lt", res, 32'd1);
      push_exp(1'b1, 32'd0, 1'b1);
      run_one(1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF);
      check("t4_slt_ge", res, 32'd0);
      check("t4_slt_zero", {31'd0, zero}, 32'd1);

      // Reset during EXEC discards the operation
      req0 = 1'b1; op0 = 4'b0010; a0 = 32'd40; b0 = 32'd2;
      tick();
      reset = 1'b1;
      req0  = 1'b0;
      tick();
      reset = 1'b0;
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_res", res, 32'd0);
      check("t5_ack0", {31'd0, ack0}, 32'd0);
      check("t5_ack1", {31'd0, ack1}, 32'd0);
      tick();
      check("t5_no_late_ack", {31'd0, ack0 | ack1}, 32'd0);
      push_exp(1'b0, 32'd17, 1'b0);
      run_one(1'b0, 4'b0010, 32'd8, 32'd9);
      check("t5_after_reset", res, 32'd17);

      // Operand change and req drop during EXEC do not disturb the operation
      push_exp(1'b0, 32'd12, 1'b0);
      req0 = 1'b1; op0 = 4'b0010; a0 = 32'd5; b0 = 32'd7;
      tick();
      a0   = 32'd99;
      req0 = 1'b0;
      tick();
      check("t6_ack0", {31'd0, ack0}, 32'd1);
      check("t6_res", res, 32'd12);
      tick();

      // Undefined opcode passes through; ULA gives S=0, Z=1
      push_exp(1'b1, 32'd0, 1'b1);
      req1 = 1'b1; op1 = 4'b1111; a1 = 32'd123; b1 = 32'd456;
      tick();
      check("t7_op_pass", {28'd0, ula_op}, 32'hF);
      req1 = 1'b0;
      tick();
      tick();

      tick();
      tick();
      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
